// File: rtl/bus_pkg.sv
// Shared bus types: transfer size encoding and the arbiter FSM state.
// Used by bus_arbiter, rr_picker's users and the other bus masters.
package bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } data_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

    // Width of the optional access wait counter.
    localparam int WAIT_CNT_W = 16;

    // Size code 3 is not a real transfer size; treat it as a full word.
    function automatic data_size_e norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SIZE_WORD : data_size_e'(raw);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the shared bus.
// slave  : the arbiter's view (takes requests and memory replies).
// master : the environment's view (bus masters plus memory model).
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    // Requester side, master i packed at [32i+31:32i] / [2i+1:2i]
    logic [NUM_MASTERS-1:0]    req;
    logic [NUM_MASTERS-1:0]    req_write;
    logic [32*NUM_MASTERS-1:0] req_address;
    logic [32*NUM_MASTERS-1:0] req_data;
    logic [2*NUM_MASTERS-1:0]  req_size;
    logic [NUM_MASTERS-1:0]    grant;
    logic [NUM_MASTERS-1:0]    ack;
    logic                      error;
    logic [31:0]               read_data;

    // Memory side
    logic [31:0]               mem_address;
    logic [31:0]               mem_data_out;
    logic [1:0]                mem_data_size;
    logic                      mem_read;
    logic                      mem_write;
    logic [31:0]               mem_data_in;
    logic                      mem_ready;

    modport slave (
        input  req, req_write, req_address, req_data, req_size,
        input  mem_data_in, mem_ready,
        output grant, ack, error, read_data,
        output mem_address, mem_data_out, mem_data_size, mem_read, mem_write
    );

    modport master (
        output req, req_write, req_address, req_data, req_size,
        output mem_data_in, mem_ready,
        input  grant, ack, error, read_data,
        input  mem_address, mem_data_out, mem_data_size, mem_read, mem_write
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the search starts one past last_grant
// (wrapping at N) and the first set request bit wins. Reusable for any
// shared resource. Outputs are all zero when no request is set.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] index_o
);

    // Walk the N candidates in priority order and keep the first requester.
    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        logic       found;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        winner_o = '0;
        index_o  = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_grant_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found              = 1'b1;
                index_o            = cand_idx;
                winner_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared external memory bus.
// IDLE picks and latches one request, ACCESS drives the memory strobes
// until mem_ready, RESPOND pulses ack to the owner for one cycle.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to abort accesses that
// wait TIMEOUT_CYCLES cycles without mem_ready (error = 1 on the ack).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clock,
    input logic          reset,
    bus_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Reject configurations the counter and picker cannot represent.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** WAIT_CNT_W)) begin : g_bad_cfg
        $error("bus_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
    end

    arb_state_e       state_q,      state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] owner_q,      owner_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic             write_q,      write_d;
    logic [31:0]      addr_q,       addr_d;
    logic [31:0]      data_q,       data_d;
    data_size_e       size_q,       size_d;
    logic [31:0]      read_data_q,  read_data_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic                  error_q,    error_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_index;

    // Per-master views of the packed request fields.
    logic [31:0] req_addr_arr [NUM_MASTERS];
    logic [31:0] req_data_arr [NUM_MASTERS];
    logic [1:0]  req_size_arr [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign req_addr_arr[g] = bus.req_address[32*g +: 32];
        assign req_data_arr[g] = bus.req_data[32*g +: 32];
        assign req_size_arr[g] = bus.req_size[2*g +: 2];
    end

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_onehot),
        .index_o      (pick_index)
    );

    // Next-state logic: arbitration, access completion and response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        size_d       = size_q;
        read_data_d  = read_data_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        error_d      = error_q;
        // Zero outside ACCESS, so it is already clear on entry.
        wait_cnt_d   = (state_q == ACCESS && !bus.mem_ready) ? wait_cnt_q + 1'b1 : '0;
`endif

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = pick_index;
                    grant_d = pick_onehot;
                    write_d = bus.req_write[pick_index];
                    addr_d  = req_addr_arr[pick_index];
                    data_d  = req_data_arr[pick_index];
                    size_d  = norm_size(req_size_arr[pick_index]);
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                // A ready in the timeout cycle still counts as a normal completion.
                if (bus.mem_ready) begin
                    if (!write_q) begin
                        read_data_d = bus.mem_data_in;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    state_d = RESPOND;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    if (!write_q) begin
                        read_data_d = 32'h0;
                    end
                    error_d = 1'b1;
                    state_d = RESPOND;
                end
`endif
            end

            RESPOND: begin
                last_grant_d = owner_q;
                grant_d      = '0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: all control and datapath registers are reset so every output reads 0 after reset.
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            size_q       <= SIZE_BYTE;
            read_data_q  <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            error_q      <= 1'b0;
            wait_cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            size_q       <= size_d;
            read_data_q  <= read_data_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            error_q      <= error_d;
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    // Outputs decoded from state; the memory side is quiet outside ACCESS.
    assign bus.grant         = grant_q;
    assign bus.ack           = (state_q == RESPOND) ? grant_q : '0;
    assign bus.mem_read      = (state_q == ACCESS) && !write_q;
    assign bus.mem_write     = (state_q == ACCESS) && write_q;
    assign bus.mem_address   = (state_q == ACCESS) ? addr_q : '0;
    assign bus.mem_data_out  = (state_q == ACCESS) ? data_q : '0;
    assign bus.mem_data_size = (state_q == ACCESS) ? size_q : SIZE_BYTE;
    assign bus.read_data     = (state_q == RESPOND) ? read_data_q : '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    assign bus.error         = (state_q == RESPOND) && error_q;
`else
    assign bus.error         = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a vector table of single-master
// transactions, hand-written reset/fairness/drop sequences, randomized
// multi-master traffic against a transaction-level round-robin model, and
// (with BUS_ARBITER_TIMEOUT_EN) the timeout abort.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int NM = 2;
    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bus_arbiter_if #(.NUM_MASTERS(NM)) bif ();

    bus_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;

    // Bench-side state of each bus master and of the arbiter model.
    logic        m_req   [NM];
    logic        m_write [NM];
    logic [31:0] m_addr  [NM];
    logic [31:0] m_data  [NM];
    logic [1:0]  m_size  [NM];
    int          last_model;

    typedef struct {
        int          m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          wt;
        logic [31:0] rdata;
        int          exp_win;
        logic [1:0]  exp_size;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] onehot(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: search from last+1 modulo NM, first requester wins.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (last + k) % NM;
            if (m_req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [1:0] exp_size(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    task automatic apply();
        for (int m = 0; m < NM; m++) begin
            bif.req[m]                = m_req[m];
            bif.req_write[m]          = m_write[m];
            bif.req_address[32*m +: 32] = m_addr[m];
            bif.req_data[32*m +: 32]    = m_data[m];
            bif.req_size[2*m +: 2]      = m_size[m];
        end
    endtask

    task automatic new_req(input int m);
        m_req[m]   = 1'b1;
        m_write[m] = 1'($urandom_range(0, 1));
        m_addr[m]  = $urandom;
        m_data[m]  = $urandom;
        m_size[m]  = 2'($urandom_range(0, 3));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(bif.grant), 32'h0);
        check({tag, "_ack"}, 32'(bif.ack), 32'h0);
        check({tag, "_error"}, 32'(bif.error), 32'h0);
        check({tag, "_read_data"}, bif.read_data, 32'h0);
        check({tag, "_mem_address"}, bif.mem_address, 32'h0);
        check({tag, "_mem_data_out"}, bif.mem_data_out, 32'h0);
        check({tag, "_mem_size"}, 32'(bif.mem_data_size), 32'h0);
        check({tag, "_mem_read"}, 32'(bif.mem_read), 32'h0);
        check({tag, "_mem_write"}, 32'(bif.mem_write), 32'h0);
    endtask

    // One complete transaction, entered with the DUT in IDLE and left with
    // the DUT back in IDLE. Memory answers after wait_cycles extra cycles.
    task automatic one_txn(input int wait_cycles, input logic [31:0] rdata,
                           input bit drop_early, input bit release_owner,
                           output int winner, output logic [1:0] obs_size,
                           output logic [31:0] obs_rdata);
        int          w;
        logic        ew;
        logic [31:0] ea, ed;
        logic [1:0]  es;
        apply();
        w        = rr_pick(last_model);
        winner   = w;
        obs_size = 2'd0;
        obs_rdata = 32'h0;
        if (w < 0) begin
            total++;
            bad++;
            $display("FAIL arb_setup: no request pending");
            return;
        end
        ew = m_write[w];
        ea = m_addr[w];
        ed = m_data[w];
        es = exp_size(m_size[w]);
        bif.mem_ready = 1'($urandom_range(0, 1));
        bif.mem_data_in = $urandom;
        step();
        check("access_grant", 32'(bif.grant), onehot(w));
        obs_size = bif.mem_data_size;
        if (drop_early) begin
            m_req[w]  = 1'b0;
            m_addr[w] = ~m_addr[w];
            m_data[w] = ~m_data[w];
            apply();
        end
        for (int k = 0; k <= wait_cycles; k++) begin
            check("access_mem_read", 32'(bif.mem_read), 32'(!ew));
            check("access_mem_write", 32'(bif.mem_write), 32'(ew));
            check("access_mem_address", bif.mem_address, ea);
            check("access_mem_data_out", bif.mem_data_out, ed);
            check("access_mem_size", 32'(bif.mem_data_size), 32'(es));
            check("access_ack_low", 32'(bif.ack), 32'h0);
            bif.mem_ready   = (k == wait_cycles);
            bif.mem_data_in = (k == wait_cycles) ? rdata : $urandom;
            step();
        end
        check("respond_ack", 32'(bif.ack), onehot(w));
        check("respond_error", 32'(bif.error), 32'h0);
        check("respond_strobes", 32'({bif.mem_read, bif.mem_write}), 32'h0);
        if (!ew) begin
            check("respond_read_data", bif.read_data, rdata);
        end
        obs_rdata = bif.read_data;
        last_model = w;
        if (release_owner) m_req[w] = 1'b0;
        else               new_req(w);
        apply();
        bif.mem_ready   = 1'($urandom_range(0, 1));
        bif.mem_data_in = $urandom;
        step();
        check("idle_ack", 32'(bif.ack), 32'h0);
        check("idle_grant", 32'(bif.grant), 32'h0);
        check("idle_strobes", 32'({bif.mem_read, bif.mem_write}), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        int          w;
        logic [1:0]  osz;
        logic [31:0] ord;
        int          fair_exp [6];

        vecs[0] = '{m:0, wr:1'b0, addr:32'h0000_0010, data:32'h0, size:2'd2, wt:2,
                    rdata:32'hDEAD_BEEF, exp_win:0, exp_size:2'd2, exp_rd:32'hDEAD_BEEF};
        vecs[1] = '{m:1, wr:1'b1, addr:32'h0000_0100, data:32'h1234_5678, size:2'd1, wt:0,
                    rdata:32'h5555_5555, exp_win:1, exp_size:2'd1, exp_rd:32'hDEAD_BEEF};
        vecs[2] = '{m:0, wr:1'b1, addr:32'h0000_0203, data:32'h0000_00A5, size:2'd0, wt:1,
                    rdata:32'h6666_6666, exp_win:0, exp_size:2'd0, exp_rd:32'hDEAD_BEEF};
        vecs[3] = '{m:1, wr:1'b0, addr:32'h8000_0000, data:32'hFFFF_FFFF, size:2'd3, wt:3,
                    rdata:32'hCAFE_F00D, exp_win:1, exp_size:2'd2, exp_rd:32'hCAFE_F00D};
        vecs[4] = '{m:0, wr:1'b0, addr:32'h0000_0042, data:32'h0, size:2'd1, wt:0,
                    rdata:32'h0000_0001, exp_win:0, exp_size:2'd1, exp_rd:32'h0000_0001};
        fair_exp = '{0, 1, 0, 1, 0, 1};

        for (int m = 0; m < NM; m++) begin
            m_req[m] = 1'b0; m_write[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0; m_size[m] = '0;
        end
        apply();
        bif.mem_ready   = 1'b0;
        bif.mem_data_in = 32'h0;
        last_model      = NM - 1;

        // Reset state
        reset = 1'b0;
        step();
        step();
        check_zero("reset");
        reset = 1'b1;

        // Vector table: one master at a time
        for (int i = 0; i < 5; i++) begin
            m_req[vecs[i].m]   = 1'b1;
            m_write[vecs[i].m] = vecs[i].wr;
            m_addr[vecs[i].m]  = vecs[i].addr;
            m_data[vecs[i].m]  = vecs[i].data;
            m_size[vecs[i].m]  = vecs[i].size;
            one_txn(vecs[i].wt, vecs[i].rdata, 1'b0, 1'b1, w, osz, ord);
            check($sformatf("vec%0d_winner", i), 32'(w), 32'(vecs[i].exp_win));
            check($sformatf("vec%0d_size", i), 32'(osz), 32'(vecs[i].exp_size));
            check($sformatf("vec%0d_read_data", i), ord, vecs[i].exp_rd);
        end

        // Reset mid-access: master 1 wins (master 0 was last), then reset
        new_req(0);
        new_req(1);
        apply();
        w = rr_pick(last_model);
        step();
        check("rst_access_grant", 32'(bif.grant), onehot(w));
        reset = 1'b0;
        bif.mem_ready = 1'b1;
        step();
        check_zero("rst_mid");
        reset = 1'b1;
        last_model = NM - 1;

        // Fairness with both masters requesting continuously
        for (int i = 0; i < 6; i++) begin
            one_txn(0, $urandom, 1'b0, 1'b0, w, osz, ord);
            check($sformatf("fair%0d_winner", i), 32'(w), 32'(fair_exp[i]));
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;

        // Request dropped in the first ACCESS cycle still completes
        new_req(0);
        m_write[0] = 1'b0;
        one_txn(2, 32'h0BAD_F00D, 1'b1, 1'b1, w, osz, ord);
        check("drop_read_data", ord, 32'h0BAD_F00D);

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            bit any;
            any = 1'b0;
            for (int m = 0; m < NM; m++) begin
                if (!m_req[m] && $urandom_range(0, 1) == 1) new_req(m);
                if (m_req[m]) any = 1'b1;
            end
            if (!any) new_req($urandom_range(0, NM - 1));
            one_txn($urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), w, osz, ord);
        end
        for (int m = 0; m < NM; m++) m_req[m] = 1'b0;
        apply();
        step();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Timeout: memory never answers, abort exactly TO cycles into ACCESS
        new_req(0);
        m_write[0] = 1'b0;
        apply();
        bif.mem_ready = 1'b0;
        step();
        for (int k = 0; k < TO; k++) begin
            check("to_ack_low", 32'(bif.ack), 32'h0);
            check("to_mem_read", 32'(bif.mem_read), 32'h1);
            bif.mem_ready = 1'b0;
            step();
        end
        check("to_ack", 32'(bif.ack), onehot(0));
        check("to_error", 32'(bif.error), 32'h1);
        check("to_read_data", bif.read_data, 32'h0);
        last_model = 0;
        m_req[0] = 1'b0;
        apply();
        step();
        // Ready in the same cycle as the timeout wins
        new_req(1);
        m_write[1] = 1'b0;
        one_txn(TO - 1, 32'h7777_1234, 1'b0, 1'b1, w, osz, ord);
        check("to_race_read_data", ord, 32'h7777_1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
